// File: rtl/l2_bus_arbiter_2port.sv
// rtl/l2_bus_arbiter_2port.sv - round-robin L2 bus arbiter sequencing I/D cache line bursts
module l2_bus_arbiter_2port #(
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 64,
    localparam int BW     = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_rd,
    input  logic          req0_wr,
    input  logic [31:0]   req0_addr,
    input  logic [31:0]   req0_wr_data,
    input  logic          req1_rd,
    input  logic          req1_wr,
    input  logic [31:0]   req1_addr,
    input  logic [31:0]   req1_wr_data,
    output logic          gnt0_rd,
    output logic          gnt0_wr,
    output logic          gnt1_rd,
    output logic          gnt1_wr,
    output logic [BW-1:0] beat_idx,
    output logic          beat_valid,
    output logic [31:0]   rd_data_o,
    output logic          done_o,
    output logic          err_o,
    output logic          l2_mem_en,
    output logic          l2_mem_wr_en,
    output logic [31:0]   l2_mem_addr,
    output logic [31:0]   l2_mem_wr_data,
    input  logic [31:0]   l2_mem_rd_data,
    input  logic          l2_mem_ready
);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t          state;
    logic            owner;
    logic            dir_wr;
    logic            last_owner;
    logic [29-BW:0]  line_hi;
    logic [TW-1:0]   tcnt;

    logic any_req;
    logic pick;
    logic pick_wr;
    logic owner_req;
    logic beat_last;
    logic timed_out;
    logic xfer_end;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{req0_addr[BW+1:0], req1_addr[BW+1:0]};

    // The requester that did not own the bus last gets first refusal; writes beat reads.
    always_comb begin
        any_req   = req0_rd | req0_wr | req1_rd | req1_wr;
        pick      = last_owner ? !(req0_rd | req0_wr) : (req1_rd | req1_wr);
        pick_wr   = pick ? req1_wr : req0_wr;
        owner_req = owner ? (dir_wr ? req1_wr : req1_rd) : (dir_wr ? req0_wr : req0_rd);
        beat_last = l2_mem_ready && (beat_idx == LAST_BEAT);
        timed_out = !l2_mem_ready && (tcnt == TMO_LAST);
        xfer_end  = (state == XFER) && (!owner_req || beat_last || timed_out);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            dir_wr       <= 1'b0;
            last_owner   <= 1'b1;
            line_hi      <= '0;
            beat_idx     <= '0;
            tcnt         <= '0;
            gnt0_rd      <= 1'b0;
            gnt0_wr      <= 1'b0;
            gnt1_rd      <= 1'b0;
            gnt1_wr      <= 1'b0;
            l2_mem_en    <= 1'b0;
            l2_mem_wr_en <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= XFER;
                        owner        <= pick;
                        dir_wr       <= pick_wr;
                        line_hi      <= pick ? req1_addr[31:BW+2] : req0_addr[31:BW+2];
                        beat_idx     <= '0;
                        tcnt         <= '0;
                        gnt0_rd      <= !pick && !pick_wr;
                        gnt0_wr      <= !pick && pick_wr;
                        gnt1_rd      <= pick && !pick_wr;
                        gnt1_wr      <= pick && pick_wr;
                        l2_mem_en    <= 1'b1;
                        l2_mem_wr_en <= pick_wr;
                    end
                end
                XFER: begin
                    // A dropped request abandons the burst silently, even on a ready cycle.
                    if (!owner_req) begin
                        state <= IDLE;
                    end else if (l2_mem_ready) begin
                        tcnt     <= '0;
                        beat_idx <= beat_idx + BW'(1);
                        if (beat_last) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (xfer_end) begin
                gnt0_rd      <= 1'b0;
                gnt0_wr      <= 1'b0;
                gnt1_rd      <= 1'b0;
                gnt1_wr      <= 1'b0;
                l2_mem_en    <= 1'b0;
                l2_mem_wr_en <= 1'b0;
                last_owner   <= owner;
            end
        end
    end

    assign beat_valid     = (state == XFER) && !dir_wr && l2_mem_ready;
    assign rd_data_o      = beat_valid ? l2_mem_rd_data : '0;
    assign l2_mem_wr_data = l2_mem_wr_en ? (owner ? req1_wr_data : req0_wr_data) : '0;
    assign l2_mem_addr    = {line_hi, beat_idx, 2'b00};

endmodule

// File: tb/tb_l2_bus_arbiter_2port.sv
// tb/tb_l2_bus_arbiter_2port.sv - directed and random checks of the L2 arbiter against a burst-level model
module tb_l2_bus_arbiter_2port;
    localparam int BEATS   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_rd = 1'b0, req0_wr = 1'b0, req1_rd = 1'b0, req1_wr = 1'b0;
    logic [31:0] req0_addr = '0, req0_wr_data = '0, req1_addr = '0, req1_wr_data = '0;
    logic        gnt0_rd, gnt0_wr, gnt1_rd, gnt1_wr;
    logic [1:0]  beat_idx;
    logic        beat_valid, done_o, err_o, l2_mem_en, l2_mem_wr_en;
    logic [31:0] rd_data_o, l2_mem_addr, l2_mem_wr_data;
    logic [31:0] l2_mem_rd_data = '0;
    logic        l2_mem_ready = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    // Burst-level reference: a burst is either running, just finished, or absent.
    bit          m_busy, m_done, m_err, m_owner, m_wr, m_last;
    logic [31:0] m_line;
    int          m_beat, m_stall;

    always #5 clk = ~clk;

    l2_bus_arbiter_2port #(.BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wr_data(req0_wr_data),
        .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wr_data(req1_wr_data),
        .gnt0_rd(gnt0_rd), .gnt0_wr(gnt0_wr), .gnt1_rd(gnt1_rd), .gnt1_wr(gnt1_wr),
        .beat_idx(beat_idx), .beat_valid(beat_valid), .rd_data_o(rd_data_o),
        .done_o(done_o), .err_o(err_o),
        .l2_mem_en(l2_mem_en), .l2_mem_wr_en(l2_mem_wr_en),
        .l2_mem_addr(l2_mem_addr), .l2_mem_wr_data(l2_mem_wr_data),
        .l2_mem_rd_data(l2_mem_rd_data), .l2_mem_ready(l2_mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_owner = 0; m_wr = 0; m_last = 1;
        m_line = '0; m_beat = 0; m_stall = 0;
    endtask

    task automatic model_check();
        bit rv;
        rv = m_busy && !m_wr && l2_mem_ready;
        check("gnt0_rd", 32'(gnt0_rd), 32'(m_busy && !m_owner && !m_wr));
        check("gnt0_wr", 32'(gnt0_wr), 32'(m_busy && !m_owner && m_wr));
        check("gnt1_rd", 32'(gnt1_rd), 32'(m_busy && m_owner && !m_wr));
        check("gnt1_wr", 32'(gnt1_wr), 32'(m_busy && m_owner && m_wr));
        check("mem_en", 32'(l2_mem_en), 32'(m_busy));
        check("mem_wr_en", 32'(l2_mem_wr_en), 32'(m_busy && m_wr));
        check("beat_idx", 32'(beat_idx), m_beat);
        check("beat_valid", 32'(beat_valid), 32'(rv));
        check("rd_data", rd_data_o, rv ? l2_mem_rd_data : 32'h0);
        check("done", 32'(done_o), 32'(m_done));
        check("err", 32'(err_o), 32'(m_done && m_err));
        check("addr", l2_mem_addr, (m_line & ~32'(BEATS * 4 - 1)) + 32'(m_beat * 4));
        check("wr_data", l2_mem_wr_data,
              (m_busy && m_wr) ? (m_owner ? req1_wr_data : req0_wr_data) : 32'h0);
    endtask

    task automatic model_step();
        bit h0, h1, pick, held;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_done) begin
            m_done = 0;
            m_err  = 0;
        end else if (!m_busy) begin
            h0 = req0_rd || req0_wr;
            h1 = req1_rd || req1_wr;
            if (h0 || h1) begin
                if (h0 && h1) pick = !m_last;
                else          pick = h1;
                m_busy  = 1;
                m_owner = pick;
                m_wr    = pick ? req1_wr : req0_wr;
                m_line  = pick ? req1_addr : req0_addr;
                m_beat  = 0;
                m_stall = 0;
            end
        end else begin
            if (m_owner) held = m_wr ? req1_wr : req1_rd;
            else         held = m_wr ? req0_wr : req0_rd;
            if (!held) begin
                m_busy = 0;
                m_last = m_owner;
            end else if (l2_mem_ready) begin
                m_stall = 0;
                if (m_beat == BEATS - 1) begin
                    m_busy = 0; m_done = 1; m_err = 0; m_last = m_owner; m_beat = 0;
                end else begin
                    m_beat++;
                end
            end else begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_busy = 0; m_done = 1; m_err = 1; m_last = m_owner;
                end
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are compared at the falling edge.
    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int max, output bit got);
        got = 0;
        for (int i = 0; i < max && !got; i++) begin
            cycle();
            got = done_o;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit got;
        bit prev;
        int owners[$];
        int stall_left;

        model_reset();
        #3;
        model_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Single read, ready tied high.
        req0_rd = 1'b1; req0_addr = 32'h0000_1234; l2_mem_ready = 1'b1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            l2_mem_rd_data = 32'hA0 + 32'(k);
            #1;
            check("sr_gnt", 32'(gnt0_rd), 32'd1);
            check("sr_addr", l2_mem_addr, 32'h1230 + 32'(4 * k));
            check("sr_valid", 32'(beat_valid), 32'd1);
            check("sr_data", rd_data_o, 32'hA0 + 32'(k));
            cycle();
        end
        #1;
        check("sr_done", 32'(done_o), 32'd1);
        check("sr_err", 32'(err_o), 32'd0);
        req0_rd = 1'b0;
        cycle(); cycle();

        // Both requesters reading continuously from reset alternate 0,1,0,1.
        do_reset();
        req0_rd = 1'b1; req1_rd = 1'b1;
        req0_addr = $urandom; req1_addr = $urandom;
        prev = 0;
        for (int i = 0; i < 60 && owners.size() < 4; i++) begin
            cycle();
            if ((gnt0_rd || gnt1_rd) && !prev) owners.push_back(gnt1_rd ? 1 : 0);
            prev = gnt0_rd || gnt1_rd;
        end
        check("alt_count", 32'(owners.size()), 32'd4);
        foreach (owners[i]) check("alt_owner", 32'(owners[i]), 32'(i % 2));
        req0_rd = 1'b0; req1_rd = 1'b0;
        repeat (4) cycle();

        // Write beats read within the same requester.
        req1_wr = 1'b1; req1_rd = 1'b1; req1_addr = $urandom; req1_wr_data = $urandom;
        cycle();
        check("wbr_gnt_wr", 32'(gnt1_wr), 32'd1);
        check("wbr_wr_en", 32'(l2_mem_wr_en), 32'd1);
        check("wbr_gnt_rd", 32'(gnt1_rd), 32'd0);
        wait_done(20, got);
        check("wbr_done_seen", 32'(got), 32'd1);
        req1_wr = 1'b0;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            cycle();
            got = gnt1_rd;
        end
        check("wbr_rd_follows", 32'(got), 32'd1);
        req1_rd = 1'b0;
        repeat (4) cycle();

        // Seven stalled cycles complete normally.
        req0_rd = 1'b1; l2_mem_ready = 1'b1;
        cycle(); cycle();
        l2_mem_ready = 1'b0;
        repeat (7) cycle();
        l2_mem_ready = 1'b1;
        wait_done(10, got);
        check("st7_done_seen", 32'(got), 32'd1);
        check("st7_err", 32'(err_o), 32'd0);
        req0_rd = 1'b0;
        cycle(); cycle();

        // Eight stalled cycles time out.
        req0_rd = 1'b1;
        cycle(); cycle();
        l2_mem_ready = 1'b0;
        repeat (8) cycle();
        check("to_done", 32'(done_o), 32'd1);
        check("to_err", 32'(err_o), 32'd1);
        req0_rd = 1'b0; l2_mem_ready = 1'b1;
        cycle();
        check("to_idle_en", 32'(l2_mem_en), 32'd0);
        cycle();

        // Request drop after beat 1 aborts without a done pulse.
        req0_rd = 1'b1;
        cycle(); cycle(); cycle();
        req0_rd = 1'b0; req1_rd = 1'b1;
        cycle();
        check("ab_gnt0", 32'(gnt0_rd), 32'd0);
        check("ab_done", 32'(done_o), 32'd0);
        cycle();
        check("ab_gnt1", 32'(gnt1_rd), 32'd1);
        req1_rd = 1'b0;
        cycle(); cycle();

        // Asynchronous reset during beat 2.
        req0_rd = 1'b1; req0_addr = 32'h0000_8000;
        cycle(); cycle(); cycle();
        check("rst_beat2", 32'(beat_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt_now", 32'(gnt0_rd), 32'd0);
        check("rst_en_now", 32'(l2_mem_en), 32'd0);
        model_check();
        req1_rd = 1'b1;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("rst_first_req0", 32'(gnt0_rd), 32'd1);
        req0_rd = 1'b0; req1_rd = 1'b0;
        repeat (4) cycle();

        // Random traffic.
        stall_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            if ($urandom_range(0, 11) == 0) req0_rd = ~req0_rd;
            if ($urandom_range(0, 15) == 0) req0_wr = ~req0_wr;
            if ($urandom_range(0, 11) == 0) req1_rd = ~req1_rd;
            if ($urandom_range(0, 15) == 0) req1_wr = ~req1_wr;
            req0_addr      = $urandom;
            req1_addr      = $urandom;
            req0_wr_data   = $urandom;
            req1_wr_data   = $urandom;
            l2_mem_rd_data = $urandom;
            if (stall_left > 0) begin
                l2_mem_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 39) == 0) begin
                l2_mem_ready = 1'b0;
                stall_left = $urandom_range(5, 10);
            end else begin
                l2_mem_ready = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
